// File: rtl/game_pkg.sv
// Shared game encodings and helpers for the answer-entry path.
// Controller state codes, result-state test, slot code to prime decode, entry FSM type.
package game_pkg;

   localparam logic [3:0] GS_QUESTION = 4'b0011;
   localparam logic [3:0] GS_INPUT    = 4'b0100;
   localparam logic [3:0] GS_DRAW     = 4'b0110;
   localparam logic [3:0] GS_GOOD     = 4'b1000;
   localparam logic [3:0] GS_OUCH     = 4'b1001;
   localparam logic [3:0] GS_WIN      = 4'b1010;
   localparam logic [3:0] GS_LOSE     = 4'b1011;

   localparam logic [3:0] DISP_BLANK  = 4'hF;

   typedef enum logic [1:0] {
      FSM_IDLE = 2'd0,
      FSM_HOLD = 2'd1,
      FSM_EDIT = 2'd2,
      FSM_PEND = 2'd3
   } entry_fsm_t;

   function automatic logic is_result_state(input logic [3:0] st);
      case (st)
         GS_DRAW, GS_GOOD, GS_OUCH, GS_WIN, GS_LOSE: is_result_state = 1'b1;
         default:                                    is_result_state = 1'b0;
      endcase
   endfunction

   // Codes above the supported prime table show as blank rather than a bogus digit.
   function automatic logic [3:0] code_to_prime(input logic [3:0] code);
      case (code)
         4'd0:    code_to_prime = DISP_BLANK;
         4'd1:    code_to_prime = 4'd2;
         4'd2:    code_to_prime = 4'd3;
         4'd3:    code_to_prime = 4'd5;
         4'd4:    code_to_prime = 4'd7;
         4'd5:    code_to_prime = 4'd11;
         4'd6:    code_to_prime = 4'd13;
         default: code_to_prime = DISP_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/entry_slot.sv
// One answer slot: wrapping code counter with clear, plus its registered prime display digit.
module entry_slot
   import game_pkg::*;
#(
   parameter int CODE_W   = 4,
   parameter int MAX_CODE = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              wipe,
   input  logic              clr,
   input  logic              inc,
   output logic [CODE_W-1:0] code,
   output logic [CODE_W-1:0] disp
);

   logic [CODE_W-1:0] code_r;
   logic [CODE_W-1:0] disp_r;
   logic [CODE_W-1:0] next_code_s;

   // Next code: clear wins over increment; increment wraps MAX_CODE back to 1, never to 0.
   always_comb begin
      next_code_s = code_r;
      if (clr) begin
         next_code_s = {CODE_W{1'b0}};
      end else if (inc) begin
         if (code_r >= CODE_W'(MAX_CODE)) begin
            next_code_s = CODE_W'(1);
         end else begin
            next_code_s = code_r + CODE_W'(1);
         end
      end else begin
         next_code_s = code_r;
      end
   end

   // Code register and display register; display trails the code by one edge.
   always_ff @(posedge CLK) begin
      if (RST || wipe) begin
         code_r <= {CODE_W{1'b0}};
         disp_r <= {CODE_W{1'b0}};
      end else begin
         code_r <= next_code_s;
         disp_r <= CODE_W'(code_to_prime(4'(code_r)));
      end
   end

   assign code = code_r;
   assign disp = disp_r;

endmodule

// File: rtl/answer_entry.sv
// Player answer entry and question hold: edge-detected slot buttons, commit to judge over valid/ready.
module answer_entry
   import game_pkg::*;
#(
   parameter int SLOTS    = 3,
   parameter int CODE_W   = 4,
   parameter int MAX_CODE = 4,
   parameter int Q_W      = 12
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [3:0]                STATE,
   input  logic [SLOTS-1:0]          SEL,
   input  logic                      DEC,
   input  logic                      CLR_IN,
   input  logic [Q_W-1:0]            QUESTION_IN,
   input  logic                      Q_VALID,
   input  logic                      ANS_READY,
   output logic [SLOTS*CODE_W-1:0]   ANS_OUT,
   output logic                      ANS_VALID,
   output logic [SLOTS*CODE_W-1:0]   DISP_ANS,
   output logic [Q_W-1:0]            DISP_Q,
   output logic                      QUE_OK,
   output logic                      LED
);

   localparam int AW = SLOTS * CODE_W;

   entry_fsm_t        state_r;
   logic [SLOTS-1:0]  sel_q_r;
   logic              dec_q_r;
   logic              clr_q_r;
   logic [Q_W-1:0]    q_r;
   logic              que_ok_r;
   logic              led_r;
   logic              ans_valid_r;
   logic [AW-1:0]     ans_out_r;

   logic [SLOTS-1:0]  sel_rise_s;
   logic [SLOTS-1:0]  inc_s;
   logic              dec_rise_s;
   logic              clr_rise_s;
   logic              result_s;
   logic              latch_s;
   logic              edit_s;
   logic              clear_s;
   logic              commit_s;
   logic              found_s;
   logic [AW-1:0]     codes_s;
   logic [AW-1:0]     disp_s;

   // Event decode: one EDIT event per cycle, clear over commit over lowest-index increment.
   always_comb begin
      result_s   = is_result_state(STATE);
      latch_s    = Q_VALID && (QUESTION_IN != {Q_W{1'b0}}) && !result_s;
      edit_s     = (state_r == FSM_EDIT);
      sel_rise_s = SEL & ~sel_q_r;
      dec_rise_s = DEC & ~dec_q_r;
      clr_rise_s = CLR_IN & ~clr_q_r;
      clear_s    = edit_s && clr_rise_s && !result_s;
      commit_s   = edit_s && dec_rise_s && !clr_rise_s && !result_s;
      inc_s      = {SLOTS{1'b0}};
      found_s    = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         if (edit_s && !clr_rise_s && !dec_rise_s && !result_s && !found_s && sel_rise_s[i]) begin
            inc_s[i] = 1'b1;
            found_s  = 1'b1;
         end else begin
            found_s  = found_s;
         end
      end
   end

   for (genvar g = 0; g < SLOTS; g++) begin : g_slot
      entry_slot #(
         .CODE_W   (CODE_W),
         .MAX_CODE (MAX_CODE)
      ) u_slot (
         .CLK  (CLK),
         .RST  (RST),
         .wipe (result_s),
         .clr  (clear_s),
         .inc  (inc_s[g]),
         .code (codes_s[g*CODE_W +: CODE_W]),
         .disp (disp_s[g*CODE_W +: CODE_W])
      );
   end

   // Entry FSM with question register, handshake outputs and button edge registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= FSM_IDLE;
         sel_q_r     <= {SLOTS{1'b0}};
         dec_q_r     <= 1'b0;
         clr_q_r     <= 1'b0;
         q_r         <= {Q_W{1'b0}};
         que_ok_r    <= 1'b0;
         led_r       <= 1'b0;
         ans_valid_r <= 1'b0;
         ans_out_r   <= {AW{1'b0}};
      end else begin
         sel_q_r <= SEL;
         dec_q_r <= DEC;
         clr_q_r <= CLR_IN;
         led_r   <= que_ok_r;
         if (result_s) begin
            state_r     <= FSM_IDLE;
            q_r         <= {Q_W{1'b0}};
            que_ok_r    <= 1'b0;
            ans_valid_r <= 1'b0;
            ans_out_r   <= {AW{1'b0}};
         end else begin
            if (latch_s) begin
               q_r      <= QUESTION_IN;
               que_ok_r <= 1'b1;
            end
            case (state_r)
               FSM_IDLE: begin
                  if (latch_s) state_r <= FSM_HOLD;
               end
               FSM_HOLD: begin
                  if (STATE == GS_INPUT) state_r <= FSM_EDIT;
               end
               FSM_EDIT: begin
                  if (commit_s) begin
                     ans_out_r   <= codes_s;
                     ans_valid_r <= 1'b1;
                     state_r     <= FSM_PEND;
                  end else if (STATE != GS_INPUT) begin
                     state_r <= FSM_HOLD;
                  end
               end
               FSM_PEND: begin
                  if (ANS_READY) begin
                     ans_valid_r <= 1'b0;
                     state_r     <= (STATE == GS_INPUT) ? FSM_EDIT : FSM_HOLD;
                  end
               end
               default: state_r <= FSM_IDLE;
            endcase
         end
      end
   end

   assign ANS_OUT   = ans_out_r;
   assign ANS_VALID = ans_valid_r;
   assign DISP_ANS  = disp_s;
   assign DISP_Q    = q_r;
   assign QUE_OK    = que_ok_r;
   assign LED       = led_r;

endmodule

// File: tb/tb_answer_entry.sv
// Directed bench for answer_entry: question hold, slot entry, commit handshake, clear, result wipe, reset.
module tb_answer_entry;

   localparam logic [3:0] ST_QUESTION = 4'b0011;
   localparam logic [3:0] ST_INPUT    = 4'b0100;
   localparam logic [3:0] ST_GOOD     = 4'b1000;

   logic        CLK;
   logic        RST;
   logic [3:0]  STATE;
   logic [2:0]  SEL;
   logic        DEC;
   logic        CLR_IN;
   logic [11:0] QUESTION_IN;
   logic        Q_VALID;
   logic        ANS_READY;
   logic [11:0] ANS_OUT;
   logic        ANS_VALID;
   logic [11:0] DISP_ANS;
   logic [11:0] DISP_Q;
   logic        QUE_OK;
   logic        LED;

   int total;
   int bad;

   answer_entry dut (
      .CLK         (CLK),
      .RST         (RST),
      .STATE       (STATE),
      .SEL         (SEL),
      .DEC         (DEC),
      .CLR_IN      (CLR_IN),
      .QUESTION_IN (QUESTION_IN),
      .Q_VALID     (Q_VALID),
      .ANS_READY   (ANS_READY),
      .ANS_OUT     (ANS_OUT),
      .ANS_VALID   (ANS_VALID),
      .DISP_ANS    (DISP_ANS),
      .DISP_Q      (DISP_Q),
      .QUE_OK      (QUE_OK),
      .LED         (LED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic press(input int idx);
      SEL[idx] = 1'b1;
      step(1);
      SEL[idx] = 1'b0;
      step(1);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      step(2);
      total++;
      if ({ANS_OUT, ANS_VALID, DISP_ANS, DISP_Q, QUE_OK, LED} !== 39'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want 0", {ANS_OUT, ANS_VALID, DISP_ANS, DISP_Q, QUE_OK, LED});
      end
      RST = 1'b0;
      step(1);
      total++;
      if (DISP_ANS !== 12'hFFF) begin
         bad++;
         $display("FAIL reset_blank_disp: got %h want fff", DISP_ANS);
      end
   endtask

   task automatic test_question();
      STATE       = ST_QUESTION;
      Q_VALID     = 1'b1;
      QUESTION_IN = 12'h153;
      step(1);
      Q_VALID = 1'b0;
      total++;
      if ({QUE_OK, LED, DISP_Q} !== {1'b1, 1'b0, 12'h153}) begin
         bad++;
         $display("FAIL q_latch: got que_ok=%b led=%b q=%h want 1 0 153", QUE_OK, LED, DISP_Q);
      end
      step(1);
      total++;
      if (LED !== 1'b1) begin
         bad++;
         $display("FAIL led_delay: got %b want 1", LED);
      end
      Q_VALID     = 1'b1;
      QUESTION_IN = 12'h000;
      step(1);
      Q_VALID = 1'b0;
      step(1);
      total++;
      if ({QUE_OK, DISP_Q} !== {1'b1, 12'h153}) begin
         bad++;
         $display("FAIL q_zero_ignored: got que_ok=%b q=%h want 1 153", QUE_OK, DISP_Q);
      end
   endtask

   task automatic test_sel_hold();
      STATE = ST_INPUT;
      step(1);
      SEL[0] = 1'b1;
      step(1);
      total++;
      if (DISP_ANS !== 12'hFFF) begin
         bad++;
         $display("FAIL sel_disp_latency: got %h want fff", DISP_ANS);
      end
      step(1);
      total++;
      if (DISP_ANS !== 12'hFF2) begin
         bad++;
         $display("FAIL sel_first_press: got %h want ff2", DISP_ANS);
      end
      step(8);
      SEL[0] = 1'b0;
      step(1);
      total++;
      if (DISP_ANS !== 12'hFF2) begin
         bad++;
         $display("FAIL sel_held_once: got %h want ff2", DISP_ANS);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] exp_prime [5];
      exp_prime[0] = 4'd2;
      exp_prime[1] = 4'd3;
      exp_prime[2] = 4'd5;
      exp_prime[3] = 4'd7;
      exp_prime[4] = 4'd2;
      CLR_IN = 1'b1;
      step(1);
      CLR_IN = 1'b0;
      step(1);
      total++;
      if (DISP_ANS !== 12'hFFF) begin
         bad++;
         $display("FAIL wrap_clear: got %h want fff", DISP_ANS);
      end
      for (int i = 0; i < 5; i++) begin
         press(0);
         total++;
         if (DISP_ANS !== {8'hFF, exp_prime[i]}) begin
            bad++;
            $display("FAIL wrap_press%0d: got %h want %h", i, DISP_ANS, {8'hFF, exp_prime[i]});
         end
      end
   endtask

   task automatic test_commit();
      ANS_READY = 1'b0;
      press(1);
      press(1);
      press(2);
      press(2);
      press(2);
      total++;
      if (DISP_ANS !== 12'h532) begin
         bad++;
         $display("FAIL commit_entry: got %h want 532", DISP_ANS);
      end
      DEC = 1'b1;
      step(1);
      DEC = 1'b0;
      total++;
      if ({ANS_VALID, ANS_OUT} !== {1'b1, 12'h321}) begin
         bad++;
         $display("FAIL commit_out: got v=%b out=%h want 1 321", ANS_VALID, ANS_OUT);
      end
      press(0);
      press(2);
      STATE = ST_QUESTION;
      step(2);
      total++;
      if ({ANS_VALID, ANS_OUT, DISP_ANS} !== {1'b1, 12'h321, 12'h532}) begin
         bad++;
         $display("FAIL pend_stable: got v=%b out=%h disp=%h want 1 321 532", ANS_VALID, ANS_OUT, DISP_ANS);
      end
      STATE = ST_INPUT;
      step(1);
      ANS_READY = 1'b1;
      step(1);
      ANS_READY = 1'b0;
      total++;
      if ({ANS_VALID, ANS_OUT} !== {1'b0, 12'h321}) begin
         bad++;
         $display("FAIL handshake: got v=%b out=%h want 0 321", ANS_VALID, ANS_OUT);
      end
   endtask

   task automatic test_clear();
      CLR_IN = 1'b1;
      SEL    = 3'b010;
      step(1);
      CLR_IN = 1'b0;
      SEL    = 3'b000;
      step(1);
      total++;
      if ({ANS_VALID, DISP_ANS} !== {1'b0, 12'hFFF}) begin
         bad++;
         $display("FAIL clear_priority: got v=%b disp=%h want 0 fff", ANS_VALID, DISP_ANS);
      end
   endtask

   task automatic test_back_to_back();
      ANS_READY = 1'b1;
      press(0);
      DEC = 1'b1;
      step(1);
      total++;
      if ({ANS_VALID, ANS_OUT} !== {1'b1, 12'h001}) begin
         bad++;
         $display("FAIL pulse_rise: got v=%b out=%h want 1 001", ANS_VALID, ANS_OUT);
      end
      step(1);
      total++;
      if (ANS_VALID !== 1'b0) begin
         bad++;
         $display("FAIL pulse_fall: got %b want 0", ANS_VALID);
      end
      step(1);
      total++;
      if (ANS_VALID !== 1'b0) begin
         bad++;
         $display("FAIL dec_held_once: got %b want 0", ANS_VALID);
      end
      DEC       = 1'b0;
      ANS_READY = 1'b0;
      step(1);
   endtask

   task automatic test_result();
      DEC = 1'b1;
      step(1);
      DEC = 1'b0;
      total++;
      if (ANS_VALID !== 1'b1) begin
         bad++;
         $display("FAIL result_pending: got %b want 1", ANS_VALID);
      end
      STATE = ST_GOOD;
      step(1);
      total++;
      if ({ANS_OUT, ANS_VALID, DISP_ANS, DISP_Q, QUE_OK} !== 38'd0) begin
         bad++;
         $display("FAIL result_wipe: got %h want 0", {ANS_OUT, ANS_VALID, DISP_ANS, DISP_Q, QUE_OK});
      end
      step(1);
      total++;
      if (LED !== 1'b0) begin
         bad++;
         $display("FAIL result_led: got %b want 0", LED);
      end
      STATE = ST_INPUT;
      step(1);
      press(0);
      total++;
      if ({QUE_OK, ANS_VALID, DISP_ANS} !== {1'b0, 1'b0, 12'hFFF}) begin
         bad++;
         $display("FAIL result_idle: got que_ok=%b v=%b disp=%h want 0 0 fff", QUE_OK, ANS_VALID, DISP_ANS);
      end
   endtask

   task automatic test_mid_reset();
      STATE       = ST_QUESTION;
      Q_VALID     = 1'b1;
      QUESTION_IN = 12'h0A5;
      step(1);
      Q_VALID = 1'b0;
      STATE   = ST_INPUT;
      step(2);
      press(1);
      total++;
      if (DISP_ANS !== 12'hF2F) begin
         bad++;
         $display("FAIL midrst_entry: got %h want f2f", DISP_ANS);
      end
      RST = 1'b1;
      step(1);
      total++;
      if ({ANS_OUT, ANS_VALID, DISP_ANS, DISP_Q, QUE_OK, LED} !== 39'd0) begin
         bad++;
         $display("FAIL midrst_outputs: got %h want 0", {ANS_OUT, ANS_VALID, DISP_ANS, DISP_Q, QUE_OK, LED});
      end
      RST         = 1'b0;
      STATE       = ST_QUESTION;
      Q_VALID     = 1'b1;
      QUESTION_IN = 12'h2A7;
      SEL         = 3'b100;
      step(1);
      Q_VALID = 1'b0;
      STATE   = ST_INPUT;
      step(4);
      total++;
      if ({DISP_Q, DISP_ANS} !== {12'h2A7, 12'hFFF}) begin
         bad++;
         $display("FAIL held_into_input: got q=%h disp=%h want 2a7 fff", DISP_Q, DISP_ANS);
      end
      SEL = 3'b000;
      step(1);
      press(2);
      total++;
      if (DISP_ANS !== 12'h2FF) begin
         bad++;
         $display("FAIL after_release: got %h want 2ff", DISP_ANS);
      end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      RST         = 1'b1;
      STATE       = 4'b0000;
      SEL         = 3'b000;
      DEC         = 1'b0;
      CLR_IN      = 1'b0;
      QUESTION_IN = 12'h000;
      Q_VALID     = 1'b0;
      ANS_READY   = 1'b0;
      test_reset();
      test_question();
      test_sel_hold();
      test_wrap();
      test_commit();
      test_clear();
      test_back_to_back();
      test_result();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/answer_entry.md
# answer_entry

Parametrised player-answer entry and question-hold block for the factorisation game, successor to the fixed three-slot input stage. It holds the current question for the display path, lets the player build an answer of `SLOTS` prime-factor slots with edge-detected buttons, and hands the committed answer to the judge over a valid/ready handshake. It sits between the question database, the game controller (`STATE`) and the 7-segment decoders.

## Interface
- `SLOTS`, 3: number of answer slots.
- `CODE_W`, 4: width of one slot code and one display digit.
- `MAX_CODE`, 4: highest slot code; codes 1..MAX_CODE map to primes 2,3,5,7,11,...; 0 means blank.
- `Q_W`, 12: width of the held question (difficulty and problem digits).
- `CLK` in 1: system clock.
- `RST` in 1: reset. Synchronous and active-high.
- `STATE` in 4: controller state, encoded per `game_pkg`.
- `SEL` in SLOTS: per-slot increment buttons. Already debounced and synchronised.
- `DEC` in 1: commit button.
- `CLR_IN` in 1: clear-entry button.
- `QUESTION_IN` in Q_W: question word from the database.
- `Q_VALID` in 1: `QUESTION_IN` is valid this cycle.
- `ANS_READY` in 1: judge accepts the answer.
- `ANS_OUT` out SLOTS*CODE_W: committed slot codes; slot 0 occupies the LSBs.
- `ANS_VALID` out 1: `ANS_OUT` is pending.
- `DISP_ANS` out SLOTS*CODE_W: live entry shown as prime values; 0xF marks a blank slot.
- `DISP_Q` out Q_W: held question for display.
- `QUE_OK` out 1: a question is held.
- `LED` out 1: `QUE_OK` delayed by one cycle.

## Operation
- Result states are DRAW, GOOD, OUCH, WIN and LOSE. For any result state, all codes, the question register, `QUE_OK`, `ANS_VALID`, `ANS_OUT` and `DISP_*` clear to 0 on the next edge.
- Question latch: a question is latched when `Q_VALID` is high, `QUESTION_IN` is nonzero and `STATE` is not a result state.
  - On latch, `QUESTION_IN` is copied to the register and `QUE_OK` rises.
  - A new valid question overwrites the held one.
  - A zero word is ignored.
- FSM states:
  - IDLE: no question held.
  - HOLD: question held, `STATE` is not INPUT.
  - EDIT: `STATE` is INPUT and `QUE_OK` is high.
  - PEND: `ANS_VALID` is high.
- FSM transitions:
  - IDLE→HOLD on latch.
  - HOLD↔EDIT follows `STATE`.
  - EDIT→PEND on a `DEC` rise.
  - PEND→EDIT or HOLD on `ANS_READY`.
  - Any state→IDLE on a result state or `RST`.
- Edge detection: each button is registered, and a rise is `btn & ~btn_q`. Holding a button counts as exactly one press.
- EDIT event priority, one event per cycle:
  1. `CLR_IN` rise: all codes go to 0.
  2. `DEC` rise: commit.
  3. Lowest-index `SEL[i]` rise: increment slot i's code.
- Slot increment sequence: 0→1→…→MAX_CODE→1. The code never returns to 0 except on clear.
- Commit: `ANS_OUT` is loaded with the current codes, `ANS_VALID` is set, and the entry codes are kept.
- In PEND, all buttons are ignored. `ANS_OUT` and `ANS_VALID` stay stable until `ANS_READY` is sampled high while `ANS_VALID` is high. Leaving INPUT does not drop the pending answer.
- Outside EDIT, codes hold their values and rises are discarded. Edge registers keep tracking, so a button already held when EDIT is entered does not fire.

## Timing
- Reset values: all outputs are 0, the FSM is in IDLE, and the edge registers are 0.
- Question latency: with `Q_VALID` at edge n, `DISP_Q` and `QUE_OK` are valid after edge n, and `LED` after edge n+1.
- Button latency: a button first sampled high at edge n updates the code at edge n, and `DISP_ANS` after edge n+1.
- Commit latency: a `DEC` rise at edge n gives `ANS_VALID` high after edge n.
- Handshake: when `ANS_READY` is high at edge m, `ANS_VALID` is low after m. `ANS_READY` may be held high permanently, giving a one-cycle pulse.
- Simultaneous events:
  - A result state overrides every event.
  - `RST` overrides everything.
  - A latch coinciding with a commit is legal and does not disturb `ANS_OUT`.

## Structure
- `game_pkg` holds:
  - The `STATE` encodings: QUESTION=4'b0011, INPUT=4'b0100, DRAW=4'b0110, GOOD=4'b1000, OUCH=4'b1001, WIN=4'b1010, LOSE=4'b1011.
  - The `is_result_state` function.
  - The code-to-prime function: 0→0xF, 1→2, 2→3, 3→5, 4→7.
  - The FSM state typedef.
- Sub-module `entry_slot`, instantiated SLOTS times, contains one code register with its wrap counter, its clear input and its prime decode.

## Test plan
- `RST`, then `Q_VALID` with 12'h153 → `QUE_OK`=1 after one edge, `LED`=1 after two, `DISP_Q`=12'h153. A following zero word with `Q_VALID` leaves `DISP_Q` at 12'h153.
- STATE=INPUT, `SEL[0]` held high for 10 cycles → slot 0 code=1 and `DISP_ANS[3:0]`=2. Five separate presses from code 0 → code 1, the wrap from 4 to 1.
- Codes {1,2,3} followed by a `DEC` rise with `ANS_READY`=0 → `ANS_VALID`=1 and `ANS_OUT`={3,2,1}. `SEL` presses are ignored and the output stays stable until `ANS_READY`=1, after which `ANS_VALID`=0 one edge later.
- `CLR_IN` and `SEL[1]` rise in the same cycle → all codes are 0.
- A pending answer with STATE changed to GOOD → `ANS_VALID`, `QUE_OK`, codes and `DISP_Q` all read 0 after one edge, and the FSM is in IDLE.
- Mid-entry `RST` → every output is 0. Then `SEL[2]` held through the transition into INPUT → no increment.
